// File: rtl/k2red_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | k2red_arb: round-robin share of one K2RED reducer between two        |
// | requesters, with tag tracking and credit-guarded response FIFOs.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module k2red_arb #(
  parameter int WID   = 24,
  parameter int WID2  = 12,
  parameter int LAT   = 6,
  parameter int TAGW  = 4,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [WID-1:0]  req0_data,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [WID-1:0]  req1_data,
  input  logic [TAGW-1:0] req1_tag,
  output logic [WID-1:0]  red_c,
  input  logic [WID2-1:0] red_cred,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [WID2-1:0] rsp0_data,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [WID2-1:0] rsp1_data,
  output logic [TAGW-1:0] rsp1_tag,
  output logic            busy
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_CRED_MAX = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CRED_ONE = c_CW'(1);
  localparam logic [c_AW:0]   c_PTR_ONE  = (c_AW + 1)'(1);

  logic [1:0]            w_vld, w_rsp_rdy, w_elig, w_gnt, w_push, w_pop, w_empty, w_full;
  logic [1:0][WID2-1:0]  w_hd_data;
  logic [1:0][TAGW-1:0]  w_hd_tag;
  logic [TAGW-1:0]       w_gnt_tag;
  logic                  r_ptr;
  logic [LAT-1:0]        r_pv, r_pid;
  logic [TAGW-1:0]       r_ptag [LAT];

  assign w_vld     = {req1_valid, req0_valid};
  assign w_rsp_rdy = {rsp1_ready, rsp0_ready};

  // Grants are held off during reset so ready/red_c read 0 immediately.
  always_comb begin
    w_gnt = 2'b00;
    if (rst) begin
      if (w_elig[0] && (!w_elig[1] || !r_ptr)) w_gnt[0] = 1'b1;
      else if (w_elig[1])                      w_gnt[1] = 1'b1;
    end
  end

  assign red_c     = w_gnt[0] ? req0_data : (w_gnt[1] ? req1_data : '0);
  assign w_gnt_tag = w_gnt[1] ? req1_tag : req0_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
      r_pv  <= '0;
      r_pid <= '0;
      for (int i = 0; i < LAT; i++) r_ptag[i] <= '0;
    end else begin
      if (|w_gnt) r_ptr <= w_gnt[0];
      r_pv[0]   <= |w_gnt;
      r_pid[0]  <= w_gnt[1];
      r_ptag[0] <= w_gnt_tag;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pid[i]  <= r_pid[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end
    end
  end

  // Last pipe stage lines up with red_cred for the same operation.
  assign w_push[0] = r_pv[LAT-1] & ~r_pid[LAT-1];
  assign w_push[1] = r_pv[LAT-1] &  r_pid[LAT-1];

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [WID2+TAGW-1:0] r_mem [DEPTH];
    logic [c_AW:0]        r_wp, r_rp;
    logic [c_CW-1:0]      r_cred;

    assign w_empty[n] = (r_wp == r_rp);
    assign w_full[n]  = (r_wp[c_AW] != r_rp[c_AW]) && (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);
    assign w_elig[n]  = w_vld[n] && (r_cred != '0);
    assign w_pop[n]   = w_rsp_rdy[n] && !w_empty[n];
    assign {w_hd_data[n], w_hd_tag[n]} = w_empty[n] ? '0 : r_mem[r_rp[c_AW-1:0]];

    always_ff @(posedge clk) begin
      if (w_push[n]) r_mem[r_wp[c_AW-1:0]] <= {red_cred, r_ptag[LAT-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cred <= c_CRED_MAX;
      end else begin
        if (w_push[n]) r_wp <= r_wp + c_PTR_ONE;
        if (w_pop[n])  r_rp <= r_rp + c_PTR_ONE;
        case ({w_gnt[n], w_pop[n]})
          2'b10:   r_cred <= r_cred - c_CRED_ONE;
          2'b01:   r_cred <= r_cred + c_CRED_ONE;
          default: r_cred <= r_cred;
        endcase
      end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(w_push[n] && w_full[n] && !w_pop[n]));
  end

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign rsp0_valid = !w_empty[0];
  assign rsp0_data  = w_hd_data[0];
  assign rsp0_tag   = w_hd_tag[0];
  assign rsp1_valid = !w_empty[1];
  assign rsp1_data  = w_hd_data[1];
  assign rsp1_tag   = w_hd_tag[1];
  assign busy       = (|r_pv) || !(&w_empty);

endmodule
`default_nettype wire

// File: tb/tb_k2red_arb.sv
`default_nettype none
// Bench for k2red_arb: directed stimulus, queue-based reference model
// checked every cycle, plus hand-computed spot checks.
module tb_k2red_arb;
  localparam int WID = 24, WID2 = 12, LAT = 6, TAGW = 4, DEPTH = 8;

  logic            clk, rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WID-1:0]  req0_data, req1_data, red_c;
  logic [TAGW-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic [WID2-1:0] red_cred, rsp0_data, rsp1_data;
  logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;

  k2red_arb #(.WID(WID), .WID2(WID2), .LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
    .red_c(red_c), .red_cred(red_cred),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WID2-1:0] kred(input logic [WID-1:0] c);
    return WID2'((64'(c) * 64'd169) % 64'd3329);
  endfunction

  // Reducer stub: fixed LAT-cycle delay of 169*c mod 3329.
  logic [WID-1:0] stub_d [LAT];
  initial for (int i = 0; i < LAT; i++) stub_d[i] = '0;
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) stub_d[i] <= stub_d[i-1];
    stub_d[0] <= red_c;
  end
  assign red_cred = kred(stub_d[LAT-1]);

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: ops in flight with their due cycle, response queues, credits.
  typedef struct { int due; bit id; logic [TAGW-1:0] tag; logic [WID2-1:0] res; } inflt_t;
  typedef struct { logic [WID2-1:0] d; logic [TAGW-1:0] t; } ent_t;
  inflt_t pend[$];
  ent_t   mq0[$], mq1[$];
  int     mcred0 = DEPTH, mcred1 = DEPTH;
  bit     mptr = 1'b0;

  always @(negedge clk) begin : p_cmp
    logic        e0, e1, g0, g1;
    logic [31:0] xrc, h0d, h0t, h1d, h1t;
    inflt_t      ni;
    ent_t        ne;
    cyc++;
    if (!rst) begin
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      chk("rst_red_c", 32'(red_c), 32'd0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      pend.delete(); mq0.delete(); mq1.delete();
      mcred0 = DEPTH; mcred1 = DEPTH; mptr = 1'b0;
    end else begin
      e0 = req0_valid && (mcred0 > 0);
      e1 = req1_valid && (mcred1 > 0);
      g0 = e0 && (!e1 || !mptr);
      g1 = e1 && !g0;
      xrc = g0 ? 32'(req0_data) : (g1 ? 32'(req1_data) : 32'd0);
      h0d = 0; h0t = 0; h1d = 0; h1t = 0;
      if (mq0.size() > 0) begin h0d = 32'(mq0[0].d); h0t = 32'(mq0[0].t); end
      if (mq1.size() > 0) begin h1d = 32'(mq1[0].d); h1t = 32'(mq1[0].t); end
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      chk("red_c", 32'(red_c), xrc);
      chk("rsp0_valid", 32'(rsp0_valid), 32'(mq0.size() > 0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(mq1.size() > 0));
      chk("rsp0_data", 32'(rsp0_data), h0d);
      chk("rsp0_tag", 32'(rsp0_tag), h0t);
      chk("rsp1_data", 32'(rsp1_data), h1d);
      chk("rsp1_tag", 32'(rsp1_tag), h1t);
      chk("busy", 32'(busy), 32'(pend.size() > 0 || mq0.size() > 0 || mq1.size() > 0));
      if (mq0.size() > 0 && rsp0_ready) begin void'(mq0.pop_front()); mcred0++; end
      if (mq1.size() > 0 && rsp1_ready) begin void'(mq1.pop_front()); mcred1++; end
      while (pend.size() > 0 && pend[0].due == cyc) begin
        ne.d = pend[0].res; ne.t = pend[0].tag;
        if (pend[0].id) mq1.push_back(ne); else mq0.push_back(ne);
        void'(pend.pop_front());
      end
      if (g0 || g1) begin
        ni.due = cyc + LAT;
        ni.id  = g1;
        ni.tag = g1 ? req1_tag : req0_tag;
        ni.res = kred(g1 ? req1_data : req0_data);
        pend.push_back(ni);
        if (g0) mcred0--; else mcred1--;
        mptr = g0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  gid, acc, k;
    bit  hit, found;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 24'd7; req0_tag = '0;
    req1_valid = 1'b0; req1_data = '0;    req1_tag = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready0", 32'(req0_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1; req0_valid = 1'b0;
    tick();

    // Contention: grants alternate starting with requester 0.
    req0_valid = 1'b1; req0_data = 24'd0; req0_tag = 4'd5;
    req1_valid = 1'b1; req1_data = 24'd1; req1_tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gid = req1_ready ? 1 : (req0_ready ? 0 : 2);
      chk("alt_grant", 32'(gid), 32'(i % 2));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (LAT + 4) tick();
    @(negedge clk);
    chk("alt_rsp0_data", 32'(rsp0_data), 32'd0);
    chk("alt_rsp0_tag", 32'(rsp0_tag), 32'd5);
    chk("alt_rsp1_data", 32'(rsp1_data), 32'd169);
    chk("alt_rsp1_tag", 32'(rsp1_tag), 32'd9);
    tick();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (4) tick();

    // Single op latency and value.
    req0_valid = 1'b1; req0_data = 24'd20; req0_tag = 4'd3;
    @(negedge clk);
    chk("single_accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    k = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (rsp0_valid) begin found = 1'b1; k = i; end
    end
    chk("single_latency", 32'(k), 32'(LAT + 1));
    chk("single_data", 32'(rsp0_data), 32'd51);
    chk("single_tag", 32'(rsp0_tag), 32'd3);
    repeat (3) tick();

    // Credit limit on requester 1.
    rsp1_ready = 1'b0; req1_valid = 1'b1; req1_data = 24'd100; req1_tag = 4'd0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hit = req1_ready;
      if (hit) acc++;
      tick();
      if (hit) begin req1_data = req1_data + 24'd1; req1_tag = req1_tag + 4'd1; end
    end
    chk("fill_accepts", 32'(acc), 32'(DEPTH));
    @(negedge clk);
    chk("full1_ready", 32'(req1_ready), 32'd0);
    chk("full1_head", 32'(rsp1_data), 32'd255);
    tick();
    rsp1_ready = 1'b1;
    @(negedge clk);
    tick();
    rsp1_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hit = req1_ready;
      if (hit) acc++;
      tick();
      if (hit) begin req1_data = req1_data + 24'd1; req1_tag = req1_tag + 4'd1; end
    end
    chk("refill_accepts", 32'(acc), 32'd1);
    @(negedge clk);
    chk("full1_head_adv", 32'(rsp1_data), 32'd424);
    tick();
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    repeat (12) tick();

    // Full FIFO0 with zero credit, then pop/reissue.
    rsp0_ready = 1'b0; req0_valid = 1'b1; req0_data = 24'd200; req0_tag = 4'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hit = req0_ready;
      tick();
      if (hit) begin req0_data = req0_data + 24'd1; req0_tag = req0_tag + 4'd1; end
    end
    @(negedge clk);
    chk("full0_ready", 32'(req0_ready), 32'd0);
    chk("full0_head", 32'(rsp0_data), 32'd510);
    tick();
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("full0_pop_ready", 32'(req0_ready), 32'd0);
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("full0_reissue", 32'(req0_ready), 32'd1);
    chk("full0_head_adv", 32'(rsp0_data), 32'd679);
    tick();
    req0_data = req0_data + 24'd1;
    @(negedge clk);
    chk("full0_cred_zero", 32'(req0_ready), 32'd0);
    tick();
    rsp0_ready = 1'b1;
    repeat (16) tick();
    req0_valid = 1'b0;
    repeat (16) tick();

    // Reset with ops in flight and entries queued.
    rsp0_ready = 1'b0; req0_valid = 1'b1; req0_data = 24'd50; req0_tag = 4'd2;
    @(negedge clk); tick();
    req0_data = 24'd51;
    @(negedge clk); tick();
    req0_valid = 1'b0;
    repeat (LAT + 3) tick();
    req0_valid = 1'b1; req0_data = 24'd60; req0_tag = 4'd7;
    repeat (3) begin @(negedge clk); tick(); end
    rst = 1'b0;
    #1;
    chk("arst_req0_ready", 32'(req0_ready), 32'd0);
    chk("arst_red_c", 32'(red_c), 32'd0);
    chk("arst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    tick(); tick();
    rst = 1'b1; req1_valid = 1'b1; req1_data = 24'd5; req1_tag = 4'd4;
    @(negedge clk);
    chk("post_rst_grant0", 32'(req0_ready), 32'd1);
    chk("post_rst_grant1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (16) tick();

    // Lone requester 1 gets back-to-back grants.
    req1_valid = 1'b1; req1_data = 24'd1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b2b_ready1", 32'(req1_ready), 32'd1);
      tick();
      req1_data = req1_data + 24'd7;
    end
    req1_valid = 1'b0;
    @(negedge clk);
    chk("idle_red_c", 32'(red_c), 32'd0);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("busy_low", 32'(busy), 32'd0);
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
